sram_burst_ctrl: RTL and testbench
==================================

// Module: sram_burst_ctrl
// PURPOSE
//  Clocked, multi-channel access controller in front of the on-chip SRAM model
//  (read_enable/write_enable/address/read_data/write_data). Round-robin arbitrates
//  NUM_CH requesters, holds SRAM enables for the programmed access delay, sequences
//  multi-beat bursts with auto-incrementing address, registers read data.
// PARAMETERS
//  ADDR_BITS   16  SRAM address width (word-addressed, 1 byte/word)
//  DATA_WORDS  16  words per beat; data width DW = 8*DATA_WORDS
//  NUM_CH      2   requesting channels (>=2)
//  WAIT_CYCLES 1   extra cycles enables are held per beat (access = WAIT_CYCLES+1 clks)
//  MAX_BURST   4   max beats per burst, power of 2; LB = max(1,$clog2(MAX_BURST))
// PORTS
//  clk            in   1                  system clock, rising edge
//  n_rst          in   1                  async active-low reset
//  req            in   NUM_CH             per-channel request, level
//  wr             in   NUM_CH             1=write burst, 0=read burst
//  addr           in   NUM_CH*ADDR_BITS   start address, ch i at [i*ADDR_BITS +: ADDR_BITS]
//  len            in   NUM_CH*LB          beats-1, ch i at [i*LB +: LB]
//  wdata          in   NUM_CH*DW          write data, ch i at [i*DW +: DW]
//  grant          out  NUM_CH             one-hot owner, held for whole burst
//  beat_ack       out  1                  1-clk pulse per completed beat
//  rvalid         out  1                  1-clk pulse, rdata valid (read bursts only)
//  rdata          out  DW                 registered read data
//  done           out  NUM_CH             1-clk pulse on owner's last beat
//  sram_read_en   out  1                  to SRAM read_enable
//  sram_write_en  out  1                  to SRAM write_enable
//  sram_addr      out  ADDR_BITS          to SRAM address
//  sram_wdata     out  DW                 to SRAM write_data (registered)
//  sram_rdata     in   DW                 from SRAM read_data
// BEHAVIOUR
//  Reset (n_rst=0, async): all outputs 0, state IDLE, rr pointer=0, counters 0.
//  States: IDLE -> ACCESS -> ACK -> (ACCESS | IDLE).
//  IDLE: enables low, grant=0. Any req -> pick first asserted channel at or after
//   rr pointer (wrap); on edge: grant<=onehot, latch wr/addr/len, sram_wdata<=wdata[ch],
//   beat count=0, -> ACCESS. req/wr/addr/len sampled only here.
//  ACCESS: sram_addr stable, sram_read_en=!wr or sram_write_en=wr, never both; held
//   exactly WAIT_CYCLES+1 clks, then -> ACK; reads capture rdata<=sram_rdata on exit edge.
//  ACK (1 clk): enables low; beat_ack=1; rvalid=1 if read. If beat count==len:
//   done[ch]=1, rr pointer<=ch+1 mod NUM_CH, -> IDLE (grant drops). Else: addr+=DATA_WORDS
//   mod 2^ADDR_BITS, sram_wdata<=wdata[ch] (owner presents next beat during ACK), count+=1,
//   -> ACCESS.
//  Latency (WAIT_CYCLES=1): req seen cycle t -> grant/enable t+1..t+2, beat_ack/rvalid t+3;
//   beat period WAIT_CYCLES+2; single beat done at t+3, next grant earliest t+5.
//  Owner dropping req mid-burst: ignored, burst completes. Non-owner req waits.
//  Address wrap: 0xFFF0 + 16 -> 0x0000, no error.
//  Reset mid-burst: enables drop immediately (async), no done, burst lost.
// TESTING
//  1 Reset: n_rst=0 mid-run -> all outputs 0 same cycle; after release grant=0 until req.
//  2 Single read ch0 addr=0x0100 len=0, sram_rdata=0xA5.. -> read_en high 2 clks at
//    0x0100, rvalid+done[0] at t+3, rdata=0xA5.., write_en never high.
//  3 Write burst ch1 addr=0x0040 len=3 -> sram_addr 0x0040,0x0050,0x0060,0x0070; 4
//    beat_ack, sram_wdata tracks wdata per ACK; done[1] on 4th ACK only.
//  4 req=2'b11 held continuously, len=0 -> grants alternate ch0,ch1,ch0,ch1; none lost.
//  5 Wrap: read addr=0xFFF0 len=1 -> sram_addr 0xFFF0 then 0x0000.
//  6 ch0 drops req after first beat of len=3 burst -> all 4 beats run, done[0] fires.

Source files
------------

// File: rtl/sram_burst_ctrl.sv
// Round-robin multi-channel burst controller in front of a single-port SRAM.
// Each beat holds the SRAM enables for WAIT_CYCLES+1 clocks, then acknowledges for one clock.
module sram_burst_ctrl #(
    parameter int ADDR_BITS   = 16,
    parameter int DATA_WORDS  = 16,
    parameter int NUM_CH      = 2,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_BURST   = 4,
    localparam int DW = 8 * DATA_WORDS,
    localparam int LB = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0]           wr,
    input  logic [NUM_CH*ADDR_BITS-1:0] addr,
    input  logic [NUM_CH*LB-1:0]        len,
    input  logic [NUM_CH*DW-1:0]        wdata,
    output logic [NUM_CH-1:0]           grant,
    output logic                        beat_ack,
    output logic                        rvalid,
    output logic [DW-1:0]               rdata,
    output logic [NUM_CH-1:0]           done,
    output logic                        sram_read_en,
    output logic                        sram_write_en,
    output logic [ADDR_BITS-1:0]        sram_addr,
    output logic [DW-1:0]               sram_wdata,
    input  logic [DW-1:0]               sram_rdata
);

    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WCW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t                state_reg, state_next;
    logic [NUM_CH-1:0]     grant_reg;
    logic [CW-1:0]         own_ch_reg;
    logic [CW-1:0]         rr_ptr_reg;
    logic                  wr_reg;
    logic [LB-1:0]         len_reg;
    logic [LB-1:0]         cnt_reg;
    logic [WCW-1:0]        wait_reg;
    logic [ADDR_BITS-1:0]  sram_addr_reg;
    logic [DW-1:0]         sram_wdata_reg;
    logic [DW-1:0]         rdata_reg;

    logic [ADDR_BITS-1:0]  addr_arr  [NUM_CH];
    logic [LB-1:0]         len_arr   [NUM_CH];
    logic [DW-1:0]         wdata_arr [NUM_CH];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr[gi*ADDR_BITS +: ADDR_BITS];
        assign len_arr[gi]   = len[gi*LB +: LB];
        assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end

    // First requester at or after the round-robin pointer; lowest offset wins.
    logic          pick_valid;
    logic [CW-1:0] pick_ch;
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_valid = 1'b0;
        pick_ch    = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_CH;
            if (req[idx]) begin
                pick_valid = 1'b1;
                pick_ch    = CW'(idx);
            end
        end
    end

    logic wait_done;
    logic last_beat;
    assign wait_done = (wait_reg == WCW'(WAIT_CYCLES));
    assign last_beat = (cnt_reg == len_reg);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = ACCESS;
            ACCESS:  if (wait_done) state_next = ACK;
            ACK:     state_next = last_beat ? IDLE : ACCESS;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            grant_reg      <= '0;
            own_ch_reg     <= '0;
            rr_ptr_reg     <= '0;
            wr_reg         <= 1'b0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            wait_reg       <= '0;
            sram_addr_reg  <= '0;
            sram_wdata_reg <= '0;
            rdata_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg      <= NUM_CH'(1) << pick_ch;
                        own_ch_reg     <= pick_ch;
                        wr_reg         <= wr[pick_ch];
                        len_reg        <= len_arr[pick_ch];
                        sram_addr_reg  <= addr_arr[pick_ch];
                        sram_wdata_reg <= wdata_arr[pick_ch];
                        cnt_reg        <= '0;
                        wait_reg       <= '0;
                    end
                end
                ACCESS: begin
                    if (wait_done) begin
                        wait_reg <= '0;
                        if (!wr_reg) rdata_reg <= sram_rdata;
                    end else begin
                        wait_reg <= wait_reg + WCW'(1);
                    end
                end
                ACK: begin
                    if (last_beat) begin
                        grant_reg  <= '0;
                        rr_ptr_reg <= (own_ch_reg == CW'(NUM_CH - 1)) ? '0 : own_ch_reg + CW'(1);
                    end else begin
                        // Address wraps silently at the top of the SRAM.
                        sram_addr_reg  <= sram_addr_reg + ADDR_BITS'(DATA_WORDS);
                        sram_wdata_reg <= wdata_arr[own_ch_reg];
                        cnt_reg        <= cnt_reg + LB'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so an async reset clears them at once.
    assign sram_read_en  = (state_reg == ACCESS) && !wr_reg;
    assign sram_write_en = (state_reg == ACCESS) && wr_reg;
    assign beat_ack      = (state_reg == ACK);
    assign rvalid        = (state_reg == ACK) && !wr_reg;
    assign done          = ((state_reg == ACK) && last_beat) ? grant_reg : '0;
    assign grant         = grant_reg;
    assign rdata         = rdata_reg;
    assign sram_addr     = sram_addr_reg;
    assign sram_wdata    = sram_wdata_reg;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: burst table plus hand sequences, checked by a per-beat scoreboard.
// The SRAM read data is a function of the address so every read beat has a known value.
module tb_sram_burst_ctrl;

    localparam int ADDR_BITS   = 16;
    localparam int DATA_WORDS  = 16;
    localparam int NUM_CH      = 2;
    localparam int WAIT_CYCLES = 1;
    localparam int MAX_BURST   = 4;
    localparam int DW          = 8 * DATA_WORDS;
    localparam int LB          = 2;

    logic                        clk;
    logic                        n_rst;
    logic [NUM_CH-1:0]           req;
    logic [NUM_CH-1:0]           wr;
    logic [NUM_CH*ADDR_BITS-1:0] addr;
    logic [NUM_CH*LB-1:0]        len;
    logic [NUM_CH*DW-1:0]        wdata;
    logic [NUM_CH-1:0]           grant;
    logic                        beat_ack;
    logic                        rvalid;
    logic [DW-1:0]               rdata;
    logic [NUM_CH-1:0]           done;
    logic                        sram_read_en;
    logic                        sram_write_en;
    logic [ADDR_BITS-1:0]        sram_addr;
    logic [DW-1:0]               sram_wdata;
    logic [DW-1:0]               sram_rdata;
    logic [15:0]                 rd_key;

    sram_burst_ctrl #(
        .ADDR_BITS   (ADDR_BITS),
        .DATA_WORDS  (DATA_WORDS),
        .NUM_CH      (NUM_CH),
        .WAIT_CYCLES (WAIT_CYCLES),
        .MAX_BURST   (MAX_BURST)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req           (req),
        .wr            (wr),
        .addr          (addr),
        .len           (len),
        .wdata         (wdata),
        .grant         (grant),
        .beat_ack      (beat_ack),
        .rvalid        (rvalid),
        .rdata         (rdata),
        .done          (done),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_rdata = {8{sram_addr ^ rd_key}};

    typedef struct {
        int          ch;
        bit          wr;
        logic [15:0] addr;
        int          len;
        logic [15:0] key;
        logic [15:0] exp_last;
    } vec_t;

    typedef struct {
        int          ch;
        bit          wr;
        logic [15:0] addr;
        int          beat;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit          last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;
    int    rr_model = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] wpat(input int ch, input int b);
        logic [15:0] w;
        w = {8'(ch + 1), 8'(8'h30 + b)};
        return {8{w}};
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input int ch);
        logic [NUM_CH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        return oh;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, DW'({grant, beat_ack, rvalid, done, sram_read_en, sram_write_en}), '0);
        chk({name, "_addr"}, DW'(sram_addr), '0);
        chk({name, "_wdata"}, sram_wdata, '0);
        chk({name, "_rdata"}, rdata, '0);
    endtask

    task automatic push_beats(input int ch, input bit w, input logic [15:0] a, input int l,
                              input logic [15:0] key);
        beat_t e;
        for (int b = 0; b <= l; b++) begin
            e.ch    = ch;
            e.wr    = w;
            e.addr  = a + 16'(b * DATA_WORDS);
            e.beat  = b;
            e.wdata = wpat(ch, b);
            e.rdata = {8{e.addr ^ key}};
            e.last  = (b == l);
            exp_q.push_back(e);
        end
    endtask

    // Per-cycle scoreboard: enable windows, ack timing, data and done per beat.
    initial begin
        beat_t e;
        int    en_run;
        bit    prev_last;
        en_run    = 0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                en_run    = 0;
                prev_last = 1'b0;
                continue;
            end
            if (prev_last) chk("post_done_grant", DW'(grant), '0);
            prev_last = 1'b0;
            chk("en_excl", DW'(sram_read_en & sram_write_en), '0);
            if (sram_read_en || sram_write_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_en", DW'(1), '0);
                end else begin
                    e = exp_q[0];
                    chk("beat_addr", DW'(sram_addr), DW'(e.addr));
                    chk("beat_dir", DW'(sram_write_en), DW'(e.wr));
                    chk("beat_grant", DW'(grant), DW'(onehot(e.ch)));
                    if (e.wr) chk("beat_wdata", sram_wdata, e.wdata);
                end
                en_run++;
            end else if (beat_ack) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", DW'(1), '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("enable_len", DW'(en_run), DW'(WAIT_CYCLES + 1));
                    chk("rvalid", DW'(rvalid), DW'(!e.wr));
                    if (!e.wr) chk("rdata", rdata, e.rdata);
                    chk("done", DW'(done), e.last ? DW'(onehot(e.ch)) : '0);
                    $display("beat ch%0d %s addr=%h beat=%0d last=%0d", e.ch, e.wr ? "wr" : "rd",
                             e.addr, e.beat, e.last);
                    if (e.wr && !e.last) wdata[e.ch*DW +: DW] = wpat(e.ch, e.beat + 1);
                    prev_last = e.last;
                end
                en_run = 0;
            end else begin
                if (en_run != 0) chk("ack_follows", DW'(en_run), '0);
                en_run = 0;
                chk("stray_done", DW'(done), '0);
            end
        end
    end

    task automatic run_burst(input int ch, input bit w, input logic [15:0] a, input int l,
                             input logic [15:0] key, input logic [15:0] exp_last, input bit hold_first);
        bit seen;
        wr[ch]                     = w;
        addr[ch*ADDR_BITS +: ADDR_BITS] = a;
        len[ch*LB +: LB]           = LB'(l);
        wdata[ch*DW +: DW]         = wpat(ch, 0);
        rd_key                     = key;
        push_beats(ch, w, a, l, key);
        req[ch] = 1'b1;
        @(negedge clk);
        chk("grant_lat", DW'(grant), DW'(onehot(ch)));
        if (hold_first) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (beat_ack) break;
            end
        end
        req[ch] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done[ch]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", DW'(seen), DW'(1));
        if (seen) chk("last_addr", DW'(sram_addr), DW'(exp_last));
        rr_model = (ch + 1) % NUM_CH;
        @(negedge clk);
        chk("idle_grant", DW'(grant), '0);
    endtask

    vec_t tbl[5];

    initial begin
        bit pre_en;
        int ndone;
        int c;

        tbl[0] = '{0, 1'b0, 16'h0100, 0, 16'hA5A5 ^ 16'h0100, 16'h0100};
        tbl[1] = '{1, 1'b1, 16'h0040, 3, 16'h0000, 16'h0070};
        tbl[2] = '{0, 1'b0, 16'hFFF0, 1, 16'h1234, 16'h0000};
        tbl[3] = '{1, 1'b0, 16'h0200, 2, 16'h5A5A, 16'h0220};
        tbl[4] = '{0, 1'b1, 16'hFFE0, 3, 16'h0000, 16'h0010};

        n_rst  = 1'b0;
        req    = '0;
        wr     = '0;
        addr   = '0;
        len    = '0;
        wdata  = '0;
        rd_key = '0;
        #1;
        chk_zero("por");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;

        // Reset in the middle of a write burst: strobes drop without waiting for a clock.
        wr[1] = 1'b1;
        addr[1*ADDR_BITS +: ADDR_BITS] = 16'h0600;
        len[1*LB +: LB] = LB'(3);
        wdata[1*DW +: DW] = wpat(1, 0);
        req[1] = 1'b1;
        @(negedge clk);
        pre_en = sram_write_en;
        chk("pre_reset_en", DW'(pre_en), DW'(1));
        @(negedge clk);
        req[1] = 1'b0;
        #3;
        n_rst = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        chk_zero("reset_hold");
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_grant", DW'(grant), '0);
        end
        rr_model = 0;
        mon_en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            $display("vector %0d: ch%0d wr=%0d addr=%h len=%0d", i, tbl[i].ch, tbl[i].wr,
                     tbl[i].addr, tbl[i].len);
            run_burst(tbl[i].ch, tbl[i].wr, tbl[i].addr, tbl[i].len, tbl[i].key, tbl[i].exp_last, 1'b0);
        end

        // Both channels requesting continuously: grants must alternate, none lost.
        wr = '0;
        addr[0*ADDR_BITS +: ADDR_BITS] = 16'h0400;
        addr[1*ADDR_BITS +: ADDR_BITS] = 16'h0500;
        len = '0;
        rd_key = 16'h3C3C;
        for (int k = 0; k < 4; k++) begin
            c = (rr_model + k) % NUM_CH;
            push_beats(c, 1'b0, (c == 0) ? 16'h0400 : 16'h0500, 0, 16'h3C3C);
        end
        req = 2'b11;
        ndone = 0;
        for (int i = 0; i < 100 && ndone < 4; i++) begin
            @(negedge clk);
            if (done != '0) ndone++;
        end
        req = '0;
        chk("rr_done_count", DW'(ndone), DW'(4));
        repeat (2) @(negedge clk);

        // Owner drops req after the first beat: the burst still runs to the end.
        run_burst(0, 1'b1, 16'h0300, 3, 16'h0000, 16'h0330, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_empty", DW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
